seg7_scan_driver: RTL and testbench

- Consumes the 20-bit packed display word produced by the mode blocks (four 5-bit glyph codes; leftmost digit in bits [19:15]).
- Drives the board's 4-digit common-anode 7-segment display by time-multiplexing the digits.
- Latches the input word once per frame so a digit pattern never changes partway through a scan.
- Inserts a blanking gap between digits to suppress ghosting.

---
 rtl/seg7_scan_driver_if.sv | 16 +
 rtl/seg7_scan_driver.sv | 110 +++++++++++
 tb/tb_seg7_scan_driver.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle of the scan driver: word/point inputs in, anode/segment
// drive and frame strobe out.
interface seg7_scan_driver_if;
    logic        enable;
    logic [19:0] seg_data;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_tick;

    modport master (output enable, seg_data, dp_in,
                    input  an, seg, dp_n, frame_tick);
    modport slave  (input  enable, seg_data, dp_in,
                    output an, seg, dp_n, frame_tick);
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with per-frame
// snapshot of the display word and a blanking gap at the head of each slot.
module seg7_scan_driver #(
    parameter int DIGIT_CYCLES = 100_000,
    parameter int BLANK_CYCLES = 2_000
) (
    input  logic               clk,
    input  logic               reset,
    seg7_scan_driver_if.slave  bus
);
    localparam int          CW      = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [31:0] BLANK_U = 32'(BLANK_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);

    logic [CW-1:0]   cnt;
    logic [1:0]      slot;
    logic [3:0][4:0] snap;
    logic [3:0]      snap_dp;
    logic [3:0]      an_r;
    logic [6:0]      seg_r;
    logic            dp_n_r;
    logic            tick_r;
    logic            in_blank;
    logic            frame_start;
    logic [4:0]      cur_code;
    logic            cur_dp;

    function automatic logic [6:0] decode(input logic [4:0] code);
        case (code)
            5'h00: decode = 7'b1000000;
            5'h01: decode = 7'b1111001;
            5'h02: decode = 7'b0100100;
            5'h03: decode = 7'b0110000;
            5'h04: decode = 7'b0011001;
            5'h05: decode = 7'b0010010;
            5'h06: decode = 7'b0000010;
            5'h07: decode = 7'b1111000;
            5'h08: decode = 7'b0000000;
            5'h09: decode = 7'b0010000;
            5'h0A: decode = 7'b0001000;
            5'h0B: decode = 7'b0000011;
            5'h0C: decode = 7'b1000110;
            5'h0D: decode = 7'b0100001;
            5'h0E: decode = 7'b0000110;
            5'h0F: decode = 7'b0001110;
            5'h11: decode = 7'b0001001;
            5'h12: decode = 7'b1100001;
            5'h13: decode = 7'b1000111;
            5'h14: decode = 7'b0101011;
            5'h15: decode = 7'b0100011;
            5'h16: decode = 7'b0001100;
            5'h17: decode = 7'b0101111;
            5'h18: decode = 7'b1000001;
            5'h19: decode = 7'b0010001;
            5'h1A: decode = 7'b0111111;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign in_blank    = {{(32-CW){1'b0}}, cnt} < BLANK_U;
    assign frame_start = (cnt == '0) && (slot == 2'd0);
    // slot 0 is the leftmost digit, which lives in the top field of the word
    assign cur_code    = snap[~slot];
    assign cur_dp      = snap_dp[~slot];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            slot    <= 2'd0;
            snap    <= {4{5'h10}};
            snap_dp <= 4'b0000;
            an_r    <= 4'b1111;
            seg_r   <= 7'b1111111;
            dp_n_r  <= 1'b1;
            tick_r  <= 1'b0;
        end else if (!bus.enable) begin
            an_r    <= 4'b1111;
            seg_r   <= 7'b1111111;
            dp_n_r  <= 1'b1;
            tick_r  <= 1'b0;
        end else begin
            tick_r <= frame_start;
            if (frame_start) begin
                snap    <= bus.seg_data;
                snap_dp <= bus.dp_in;
            end
            if (cnt == CNT_LAST) begin
                cnt  <= '0;
                slot <= slot + 2'd1;
            end else begin
                cnt  <= cnt + 1'b1;
            end
            // outputs follow the pre-edge counters and snapshot
            if (in_blank) begin
                an_r   <= 4'b1111;
                seg_r  <= 7'b1111111;
                dp_n_r <= 1'b1;
            end else begin
                an_r   <= ~(4'b1000 >> slot);
                seg_r  <= decode(cur_code);
                dp_n_r <= ~cur_dp;
            end
        end
    end

    assign bus.an         = an_r;
    assign bus.seg        = seg_r;
    assign bus.dp_n       = dp_n_r;
    assign bus.frame_tick = tick_r;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver: two instances (8/2 and 2/0 timing)
// compared every cycle against a frame-position reference model.
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [19:0] seg_data;
    logic [3:0]  dp_in;

    int n_chk = 0;
    int n_pass = 0;

    localparam int DC [2] = '{8, 2};
    localparam int BC [2] = '{2, 0};
    localparam logic [6:0] GLYPH [32] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
        7'h7F, 7'h09, 7'h61, 7'h47, 7'h2B, 7'h23, 7'h0C, 7'h2F,
        7'h41, 7'h11, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    seg7_scan_driver_if if0 ();
    seg7_scan_driver_if if1 ();

    assign if0.enable = enable;  assign if0.seg_data = seg_data;  assign if0.dp_in = dp_in;
    assign if1.enable = enable;  assign if1.seg_data = seg_data;  assign if1.dp_in = dp_in;

    seg7_scan_driver #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    seg7_scan_driver #(.DIGIT_CYCLES(2), .BLANK_CYCLES(0)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;

    // model state: position within the 4-slot frame plus the latched frame contents
    int         phase [2];
    logic [4:0] m_code [2][4];
    logic [3:0] m_dp [2];
    logic [3:0] e_an [2];
    logic [6:0] e_seg [2];
    logic       e_dp [2];
    logic       e_tick [2];
    int         tick1_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model(input int k);
        int s, c, d;
        if (reset) begin
            phase[k] = 0;
            for (int i = 0; i < 4; i++) m_code[k][i] = 5'h10;
            m_dp[k] = 4'b0;
            e_an[k] = 4'hF; e_seg[k] = 7'h7F; e_dp[k] = 1'b1; e_tick[k] = 1'b0;
        end else if (!enable) begin
            e_an[k] = 4'hF; e_seg[k] = 7'h7F; e_dp[k] = 1'b1; e_tick[k] = 1'b0;
        end else begin
            s = phase[k] / DC[k];
            c = phase[k] % DC[k];
            d = 3 - s;
            if (c < BC[k]) begin
                e_an[k] = 4'hF; e_seg[k] = 7'h7F; e_dp[k] = 1'b1;
            end else begin
                e_an[k] = 4'hF;
                e_an[k][d] = 1'b0;
                e_seg[k] = GLYPH[m_code[k][d]];
                e_dp[k] = ~m_dp[k][d];
            end
            e_tick[k] = (phase[k] == 0);
            if (phase[k] == 0) begin
                for (int i = 0; i < 4; i++) m_code[k][i] = seg_data[i*5 +: 5];
                m_dp[k] = dp_in;
            end
            phase[k] = (phase[k] + 1) % (4 * DC[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model(0);
        model(1);
        #1;
        chk("an0",   32'(if0.an),         32'(e_an[0]));
        chk("seg0",  32'(if0.seg),        32'(e_seg[0]));
        chk("dp0",   32'(if0.dp_n),       32'(e_dp[0]));
        chk("tick0", 32'(if0.frame_tick), 32'(e_tick[0]));
        chk("an1",   32'(if1.an),         32'(e_an[1]));
        chk("seg1",  32'(if1.seg),        32'(e_seg[1]));
        chk("dp1",   32'(if1.dp_n),       32'(e_dp[1]));
        chk("tick1", 32'(if1.frame_tick), 32'(e_tick[1]));
        if (if1.frame_tick) tick1_cnt++;
        // at most one anode may be driven
        chk("onehot0", 32'($countones(~if0.an) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_phase(input int p);
        for (int i = 0; i < 64 && phase[0] != p; i++) step();
        chk("reach_phase", 32'(phase[0]), 32'(p));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; dp_in = 4'b0;
        seg_data = {5'h01, 5'h02, 5'h03, 5'h00};
        tick1_cnt = 0;
        run(3);
        reset = 1'b0;
        // two clean frames; the short-slot instance must tick once per 8 cycles
        tick1_cnt = 0;
        run(64);
        chk("tick1_rate", 32'(tick1_cnt), 32'd8);

        run_to_phase(10);
        seg_data = {5'h11, 5'h19, 5'h05, 5'h1A};
        run(60);

        seg_data = {5'h10, 5'h1F, 5'h10, 5'h1F};
        dp_in = 4'b1010;
        run(40);

        run_to_phase(20);
        enable = 1'b0;
        run(5);
        enable = 1'b1;
        run(40);

        run_to_phase(27);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        seg_data = {5'h0A, 5'h0B, 5'h0C, 5'h0D};
        run(40);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) seg_data = 20'($urandom);
            if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            reset  = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
